// File: rtl/jtcontra_mathseq.sv
// Sequencer that runs one multiply or divide through a 007452 math chip.
// A request is latched, its operands are written to the chip register by
// register, the chip is given time to settle, and the result bytes are read
// back and held on res_lo/res_hi until the consumer accepts them.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_div               1 = divide, 0 = multiply
//   req_a, req_b          dividend/divisor, or factor A (bits 6:0) / factor B (bits 7:0)
//   res_valid/res_ready   result handshake
//   res_lo, res_hi        quotient/remainder, or product/0
//   m_cs, m_wrn, m_addr   007452 bus control (m_wrn: 0 = write, 1 = read)
//   m_dout, m_din         007452 write data / read data (m_din is combinational from m_addr)
module jtcontra_mathseq #(
    parameter int unsigned DIV_WAIT = 18,
    parameter int unsigned MUL_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_div,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_lo,
    output logic [15:0] res_hi,
    output logic        m_cs,
    output logic        m_wrn,
    output logic [2:0]  m_addr,
    output logic [7:0]  m_dout,
    input  logic [7:0]  m_din
);

    localparam int unsigned W_MAX = (DIV_WAIT > MUL_WAIT) ? DIV_WAIT : MUL_WAIT;
    localparam int unsigned CW    = (W_MAX < 2) ? 1 : $clog2(W_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WAIT,
        S_RD,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_div;
    logic [15:0]    r_a;
    logic [15:0]    r_b;
    logic [1:0]     r_step;
    logic [CW-1:0]  r_cnt;
    logic           r_req_ready;
    logic           r_res_valid;
    logic           r_cs;
    logic           r_wrn;
    logic [2:0]     r_addr;
    logic [7:0]     r_dout;
    logic [15:0]    r_lo;
    logic [15:0]    r_hi;

    logic           w_last;
    logic [1:0]     w_step_nx;
    logic           w_wait_zero;
    logic [CW-1:0]  w_wait_load;

    // Chip register address for each write step
    function automatic logic [2:0] f_wr_addr(input logic div, input logic [1:0] step);
        f_wr_addr = div ? (3'd2 + {1'b0, step}) : {1'b0, step};
    endfunction

    // Data byte for each write step: divisor then dividend, high byte first
    function automatic logic [7:0] f_wr_data(input logic div, input logic [1:0] step,
                                             input logic [15:0] a, input logic [15:0] b);
        if (div) begin
            case (step)
                2'd0:    f_wr_data = b[15:8];
                2'd1:    f_wr_data = b[7:0];
                2'd2:    f_wr_data = a[15:8];
                default: f_wr_data = a[7:0];
            endcase
        end else begin
            f_wr_data = step[0] ? b[7:0] : {1'b0, a[6:0]};
        end
    endfunction

    // Chip register address for each read step: quotient first, then remainder
    function automatic logic [2:0] f_rd_addr(input logic div, input logic [1:0] step);
        if (div) begin
            case (step)
                2'd0:    f_rd_addr = 3'd4;
                2'd1:    f_rd_addr = 3'd5;
                2'd2:    f_rd_addr = 3'd2;
                default: f_rd_addr = 3'd3;
            endcase
        end else begin
            f_rd_addr = {2'b00, step[0]};
        end
    endfunction

    assign w_last      = r_div ? (r_step == 2'd3) : (r_step == 2'd1);
    assign w_step_nx   = r_step + 2'd1;
    assign w_wait_zero = r_div ? (DIV_WAIT == 0) : (MUL_WAIT == 0);
    // Load W-1 so the WAIT state lasts exactly W cycles
    assign w_wait_load = r_div ? CW'(DIV_WAIT - 1) : CW'(MUL_WAIT - 1);

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div       <= 1'b0;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_step      <= 2'd0;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_cs        <= 1'b0;
            r_wrn       <= 1'b1;
            r_addr      <= 3'd0;
            r_dout      <= 8'd0;
            r_lo        <= 16'd0;
            r_hi        <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        // First write goes out straight from the request inputs
                        r_div       <= req_div;
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_step      <= 2'd0;
                        r_req_ready <= 1'b0;
                        r_cs        <= 1'b1;
                        r_wrn       <= 1'b0;
                        r_addr      <= f_wr_addr(req_div, 2'd0);
                        r_dout      <= f_wr_data(req_div, 2'd0, req_a, req_b);
                        r_state     <= S_WR;
                    end
                end
                S_WR: begin
                    if (!w_last) begin
                        r_step <= w_step_nx;
                        r_addr <= f_wr_addr(r_div, w_step_nx);
                        r_dout <= f_wr_data(r_div, w_step_nx, r_a, r_b);
                    end else begin
                        r_step <= 2'd0;
                        r_wrn  <= 1'b1;
                        r_dout <= 8'd0;
                        if (w_wait_zero) begin
                            r_addr  <= f_rd_addr(r_div, 2'd0);
                            r_state <= S_RD;
                        end else begin
                            r_cs    <= 1'b0;
                            r_cnt   <= w_wait_load;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_cs    <= 1'b1;
                        r_wrn   <= 1'b1;
                        r_addr  <= f_rd_addr(r_div, 2'd0);
                        r_state <= S_RD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RD: begin
                    // m_din reflects the address presented during this cycle
                    if (r_div) begin
                        case (r_step)
                            2'd0:    r_lo[7:0]  <= m_din;
                            2'd1:    r_lo[15:8] <= m_din;
                            2'd2:    r_hi[7:0]  <= m_din;
                            default: r_hi[15:8] <= m_din;
                        endcase
                    end else if (r_step[0]) begin
                        r_lo[15:8] <= m_din;
                    end else begin
                        r_lo[7:0] <= m_din;
                        r_hi      <= 16'd0;
                    end
                    if (w_last) begin
                        r_step      <= 2'd0;
                        r_cs        <= 1'b0;
                        r_wrn       <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_step <= w_step_nx;
                        r_addr <= f_rd_addr(r_div, w_step_nx);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_cs        <= 1'b0;
                    r_wrn       <= 1'b1;
                    r_res_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign res_lo    = r_lo;
    assign res_hi    = r_hi;
    assign m_cs      = r_cs;
    assign m_wrn     = r_wrn;
    assign m_addr    = r_addr;
    assign m_dout    = r_dout;

endmodule

// File: tb/tb_jtcontra_mathseq.sv
// Bench for jtcontra_mathseq: a 007452 behavioural model answers the bus,
// a scoreboard holds expected results and bus traffic per accepted request,
// and a negedge monitor compares everything the DUT presents.
module tb_jtcontra_mathseq;

    localparam int unsigned DW = 18;
    localparam int unsigned MW = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_div;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic        m_cs;
    logic        m_wrn;
    logic [2:0]  m_addr;
    logic [7:0]  m_dout;
    logic [7:0]  m_din;

    jtcontra_mathseq #(.DIV_WAIT(DW), .MUL_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_div(req_div),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lo(res_lo), .res_hi(res_hi),
        .m_cs(m_cs), .m_wrn(m_wrn), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- 007452 model ----------------
    logic [7:0]  creg [0:7];
    logic [15:0] c_dvd, c_dvs, c_quo, c_rem, c_prod;

    initial for (int i = 0; i < 8; i++) creg[i] = 8'h00;

    always @(posedge clk) if (m_cs && !m_wrn) creg[m_addr] <= m_dout;

    always_comb begin
        c_dvd  = {creg[4], creg[5]};
        c_dvs  = {creg[2], creg[3]};
        c_quo  = (c_dvs == 16'd0) ? 16'hFFFF : c_dvd / c_dvs;
        c_rem  = (c_dvs == 16'd0) ? c_dvd : c_dvd % c_dvs;
        c_prod = {9'd0, creg[0][6:0]} * {8'd0, creg[1]};
        case (m_addr)
            3'd0:    m_din = c_prod[7:0];
            3'd1:    m_din = c_prod[15:8];
            3'd2:    m_din = c_rem[7:0];
            3'd3:    m_din = c_rem[15:8];
            3'd4:    m_din = c_quo[7:0];
            3'd5:    m_din = c_quo[15:8];
            default: m_din = 8'h00;
        endcase
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;
    int n_res = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        div;
        logic [15:0] lo;
        logic [15:0] hi;
        int          t_acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] wq[$];
    logic [2:0]  rq[$];

    // Reference result straight from the arithmetic definition of the chip
    function automatic exp_t ref_model(input logic div, input logic [15:0] a,
                                       input logic [15:0] b, input int t);
        exp_t e;
        int   pa, pb;
        e.div   = div;
        e.t_acc = t;
        if (div) begin
            e.lo = (b == 16'd0) ? 16'hFFFF : a / b;
            e.hi = (b == 16'd0) ? a : a % b;
        end else begin
            pa   = int'(a) & 127;
            pb   = int'(b) & 255;
            e.lo = 16'(pa * pb);
            e.hi = 16'd0;
        end
        return e;
    endfunction

    logic        busy     = 1'b0;
    logic        rv_prev  = 1'b0;
    logic        hs_prev  = 1'b0;
    logic        after_wr = 1'b0;
    logic        cur_div  = 1'b0;
    int          gap      = 0;
    logic [15:0] held_lo, held_hi;

    // Monitor: samples on the falling edge, away from DUT updates
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            wq.delete();
            rq.delete();
            busy     = 1'b0;
            rv_prev  = 1'b0;
            hs_prev  = 1'b0;
            after_wr = 1'b0;
        end else begin
            check("req_ready", 32'(req_ready), 32'(!busy));
            if (!m_cs) check("m_wrn_idle", 32'(m_wrn), 32'd1);
            if (hs_prev) check("res_valid_drop", 32'(res_valid), 32'd0);
            hs_prev = 1'b0;

            if (m_cs && !m_wrn) begin
                if (wq.size() == 0) check("unexpected_write", 32'(m_addr), 32'hFFFF);
                else check("write", 32'({m_addr, m_dout}), 32'(wq.pop_front()));
                after_wr = 1'b1;
                gap      = 0;
            end else if (m_cs && m_wrn) begin
                if (rq.size() == 0) check("unexpected_read", 32'(m_addr), 32'hFFFF);
                else check("read_addr", 32'(m_addr), 32'(rq.pop_front()));
                if (after_wr) check("wait_gap", 32'(gap), cur_div ? DW : MW);
                after_wr = 1'b0;
            end else if (after_wr) begin
                gap++;
            end

            if (res_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(res_lo), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_lo", 32'(res_lo), 32'(e.lo));
                    check("res_hi", 32'(res_hi), 32'(e.hi));
                    check("latency", 32'(cyc - e.t_acc), e.div ? 8 + DW : 4 + MW);
                end
                held_lo = res_lo;
                held_hi = res_hi;
                n_res++;
            end else if (res_valid) begin
                check("res_lo_stable", 32'(res_lo), 32'(held_lo));
                check("res_hi_stable", 32'(res_hi), 32'(held_hi));
            end
            rv_prev = res_valid;

            if (res_valid && res_ready) begin
                busy    = 1'b0;
                hs_prev = 1'b1;
            end
            if (req_valid && req_ready) begin
                busy    = 1'b1;
                cur_div = req_div;
                exp_q.push_back(ref_model(req_div, req_a, req_b, cyc + 1));
                if (req_div) begin
                    wq.push_back({3'd2, req_b[15:8]});
                    wq.push_back({3'd3, req_b[7:0]});
                    wq.push_back({3'd4, req_a[15:8]});
                    wq.push_back({3'd5, req_a[7:0]});
                    rq.push_back(3'd4);
                    rq.push_back(3'd5);
                    rq.push_back(3'd2);
                    rq.push_back(3'd3);
                end else begin
                    wq.push_back({3'd0, 1'b0, req_a[6:0]});
                    wq.push_back({3'd1, req_b[7:0]});
                    rq.push_back(3'd0);
                    rq.push_back(3'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic rr_random = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rr_random) res_ready = 1'($urandom_range(0, 1));
    end

    // Present a request from posedge+1 and return just after its accepting edge
    task automatic do_req(input logic div, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        req_div   = div;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_div   = 1'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 500);
        if (n >= 500) check("idle_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_div   = 1'b0;
        req_a     = 16'd0;
        req_b     = 16'd0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_m_cs", 32'(m_cs), 32'd0);
        check("rst_m_wrn", 32'(m_wrn), 32'd1);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        check("rst_m_dout", 32'(m_dout), 32'd0);
        check("rst_res_lo", 32'(res_lo), 32'd0);
        check("rst_res_hi", 32'(res_hi), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Divide 1000/7 with the consumer always ready
        res_ready = 1'b1;
        do_req(1'b1, 16'd1000, 16'd7);
        wait_idle();

        // Multiply: only bits 6:0 of A are used
        do_req(1'b0, 16'h0085, 16'h0010);
        wait_idle();

        // Back-pressure: result must hold while res_ready is low
        res_ready = 1'b0;
        do_req(1'b0, 16'd100, 16'd200);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("res_valid_timeout", 32'(n), 32'd0);
        repeat (10) @(negedge clk);
        check("held_res_lo", 32'(res_lo), 32'h4E20);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_idle();

        // Request pulsed during a divide's WAIT must be ignored
        base = n_res;
        do_req(1'b1, 16'hBEEF, 16'h0123);
        repeat (6) @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_div   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle();
        check("one_result", 32'(n_res - base), 32'd1);

        // Reset on the third WAIT cycle aborts the divide
        do_req(1'b1, 16'h5555, 16'h0003);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_m_cs", 32'(m_cs), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_lo", 32'(res_lo), 32'd0);
        repeat (30) @(negedge clk);
        check("abort_quiet_cs", 32'(m_cs), 32'd0);
        @(posedge clk);
        #1;
        do_req(1'b1, 16'hFFFF, 16'h0010);
        wait_idle();

        // Divide by zero passes the chip values through
        do_req(1'b1, 16'h1234, 16'h0000);
        wait_idle();

        // Randomised traffic with random consumer back-pressure
        rr_random = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic        div;
            logic [15:0] a, b;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            div = 1'($urandom);
            a   = 16'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 15));
            do_req(div, a, b);
        end
        rr_random = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_idle();
        check("leftover_results", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/jtcontra_mathseq.md
JTCONTRA_MATHSEQ -- requirements
Module: jtcontra_mathseq

Interface
REQ-001 SHALL have parameter DIV_WAIT, default 18: cycles held between the last divide write and the first result read.
REQ-002 SHALL have parameter MUL_WAIT, default 2: cycles held between the last multiply write and the first result read.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted on an edge where req_valid & req_ready.
REQ-007 req_div  input  1  1 = divide, 0 = multiply.
REQ-008 req_a  input  16  divide: dividend; multiply: factor A (bits 6:0 used).
REQ-009 req_b  input  16  divide: divisor; multiply: factor B (bits 7:0 used).
REQ-010 res_valid  output  1  result held stable until accepted.
REQ-011 res_ready  input  1  result consumer ready.
REQ-012 res_lo  output  16  divide: quotient; multiply: product.
REQ-013 res_hi  output  16  divide: remainder; multiply: 0.
REQ-014 m_cs  output  1  chip select to the 007452 multiplier/divider.
REQ-015 m_wrn  output  1  0 = write, 1 = read.
REQ-016 m_addr  output  3  007452 register address.
REQ-017 m_dout  output  8  write data to the 007452.
REQ-018 m_din  input  8  read data from the 007452; combinational from m_addr, sampled in the same cycle.

Function
REQ-019 SHALL implement an FSM with states IDLE, WR, WAIT, RD and DONE; req_ready SHALL be 1 only in IDLE.
REQ-020 On acceptance, SHALL latch req_div, req_a and req_b, then enter WR on the next edge; req_valid while not in IDLE SHALL be ignored.
REQ-021 WR, divide: SHALL issue one write per cycle (m_cs=1, m_wrn=0) at addr 2,3,4,5 with data b[15:8], b[7:0], a[15:8], a[7:0], in that order.
REQ-022 WR, multiply: SHALL issue writes at addr 0 with data {1'b0,a[6:0]}, then at addr 1 with data b[7:0].
REQ-023 WAIT: m_cs=0 for exactly DIV_WAIT cycles (divide) or MUL_WAIT cycles (multiply), counted by an internal down-counter.
REQ-024 RD, divide: SHALL read one address per cycle (m_cs=1, m_wrn=1) at addr 4,5,2,3 and capture m_din into quo[7:0], quo[15:8], rmnd[7:0], rmnd[15:8] respectively.
REQ-025 RD, multiply: SHALL read addr 0,1 into res_lo[7:0], res_lo[15:8]; res_hi SHALL be 0.
REQ-026 DONE: res_valid=1 with res_lo/res_hi stable; on the edge with res_ready=1, SHALL clear res_valid and enter IDLE.
REQ-027 Latency: res_valid SHALL rise exactly 8+DIV_WAIT cycles after the accepting edge for divide (26 at default), and 4+MUL_WAIT cycles for multiply (6 at default).
REQ-028 res_ready already high when DONE is entered: res_valid SHALL be high for exactly one cycle; req_ready SHALL be high on the following cycle; no same-cycle result-to-request overlap.
REQ-029 m_cs SHALL be 0 in IDLE, WAIT and DONE; m_addr, m_dout and m_wrn are don't-care when m_cs=0, except m_wrn, which SHALL be 1.
REQ-030 Divisor 0 SHALL NOT be special-cased; chip values SHALL be passed through unchanged.
REQ-031 res_lo and res_hi SHALL change only during RD.

Reset
REQ-032 rst SHALL force IDLE, req_ready=1, res_valid=0, m_cs=0, m_wrn=1, m_addr=0, m_dout=0, res_lo=0, res_hi=0, and wait counter=0.
REQ-033 rst mid-operation, in any state, SHALL abort the operation with no further m_cs pulses; the partial result is discarded.

Verification
REQ-034 Divide a=1000, b=7, res_ready=1 -> writes 2:00, 3:07, 4:03, 5:E8; res_valid 26 cycles after accept; res_lo=0x008E, res_hi=0x0006.
REQ-035 Multiply a=0x0085, b=0x0010 -> writes 0:05, 1:10; res_valid after 6 cycles; res_lo=0x0050, res_hi=0.
REQ-036 Multiply a=100, b=200 with res_ready held 0 for 10 cycles -> res_valid held, res_lo=0x4E20 stable, req_ready=0 until the release edge.
REQ-037 req_valid pulsed during WAIT of a divide -> ignored, exactly one result produced, then req_ready=1.
REQ-038 rst asserted on the 3rd WAIT cycle -> next cycle IDLE, m_cs=0, res_valid=0; a new divide 0xFFFF/0x0010 then returns quo=0x0FFF, rmnd=0x000F.
REQ-039 Divisor 0, dividend 0x1234 -> completes in 26 cycles, res_lo=0xFFFF, no hang.
